fb_write_arbiter: RTL

Shares the single pixel frame-buffer write port (`mem_px_addr`, `mem_px_data`, `px_wr`) between two pixel-writing requesters, such as the game FSM and an overlay/text writer. It also contains a built-in clear sequencer that fills the whole frame buffer with a fixed colour on command. The block sits between the game-logic blocks and the VGA pixel memory, and runs entirely in the `clk` domain. Requesters must present their requests synchronous to `clk`.

---
 rtl/fb_write_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/fb_write_arbiter.sv
// Two-requester round-robin arbiter for the pixel write port plus a full-buffer clear sweep.
// Requester writes appear 1 cycle after the ready/valid transfer; ready is withheld while clearing.
module fb_write_arbiter #(
    parameter int              AW        = 8,
    parameter int              DW        = 3,
    parameter int              NPIX      = 256,
    parameter logic [DW-1:0]   CLR_COLOR = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] data0,
    output logic          ready0,
    input  logic          valid1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] data1,
    output logic          ready1,
    input  logic          clear_start,
    output logic          clear_busy,
    output logic          clear_done,
    output logic [AW-1:0] mem_px_addr,
    output logic [DW-1:0] mem_px_data,
    output logic          px_wr
);

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam logic [AW:0] LP_LAST = (AW+1)'(NPIX - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW:0]   r_cnt;
    logic [AW:0]   w_cnt_nxt;
    logic          r_last;
    logic          w_last_nxt;
    logic          r_px_wr;
    logic          w_px_wr_nxt;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] w_addr_nxt;
    logic [DW-1:0] r_data;
    logic [DW-1:0] w_data_nxt;
    logic          r_busy;
    logic          w_busy_nxt;
    logic          r_done;
    logic          w_done_nxt;
    logic          w_gnt0;
    logic          w_gnt1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_ARB;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;
        w_px_wr_nxt = 1'b0;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        case (r_state)
            ST_ARB: begin
                if (clear_start) begin
                    // The accepting edge already launches address 0 of the sweep.
                    w_px_wr_nxt = 1'b1;
                    w_addr_nxt  = '0;
                    w_data_nxt  = CLR_COLOR;
                    w_busy_nxt  = 1'b1;
                    if (LP_LAST == '0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_CLEAR;
                        w_cnt_nxt   = (AW+1)'(1);
                    end
                end else begin
                    w_gnt0 = valid0 && (!valid1 || r_last);
                    w_gnt1 = valid1 && (!valid0 || !r_last);
                    if (w_gnt0) begin
                        w_px_wr_nxt = 1'b1;
                        w_addr_nxt  = addr0;
                        w_data_nxt  = data0;
                        w_last_nxt  = 1'b0;
                    end else if (w_gnt1) begin
                        w_px_wr_nxt = 1'b1;
                        w_addr_nxt  = addr1;
                        w_data_nxt  = data1;
                        w_last_nxt  = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                w_px_wr_nxt = 1'b1;
                w_addr_nxt  = r_cnt[AW-1:0];
                w_data_nxt  = CLR_COLOR;
                w_busy_nxt  = 1'b1;
                // Leave on the edge launching the final write so a requester can follow without a bubble.
                if (r_cnt == LP_LAST) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_ARB;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + (AW+1)'(1);
                end
            end
            default: begin
                w_state_nxt = ST_ARB;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_last  <= 1'b1;
            r_px_wr <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_last_nxt;
            r_px_wr <= w_px_wr_nxt;
            r_addr  <= w_addr_nxt;
            r_data  <= w_data_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign ready0      = rst && w_gnt0;
    assign ready1      = rst && w_gnt1;
    assign px_wr       = r_px_wr;
    assign mem_px_addr = r_addr;
    assign mem_px_data = r_data;
    assign clear_busy  = r_busy;
    assign clear_done  = r_done;

endmodule
